// File: rtl/register_bank_32x32.sv
// Two-read/one-write 32x32 general-register bank with GR0 hardwired to zero and a sequential clear engine.
// Latency: reads are registered, so data appears one cycle after the address; writes become visible the same cycle through the bypass.
// Backpressure: none; writes presented while BUSY is high are dropped, and CLR while BUSY is high is ignored.
module register_bank_32x32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             LE,
    input  logic [4:0]       RW,
    input  logic [WIDTH-1:0] PW,
    input  logic [4:0]       RA,
    input  logic [4:0]       RB,
    output logic [WIDTH-1:0] PA,
    output logic [WIDTH-1:0] PB,
    input  logic             CLR,
    output logic             BUSY
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // GR1..GR31 only; GR0 has no storage.
    logic [WIDTH-1:0] gr_q [1:31];

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pa_q, pa_d;
    logic [WIDTH-1:0] pb_q, pb_d;

    logic             busy;
    logic             wr_en;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    assign busy  = (state_q == CLEAR);
    // A write to GR0 or during a clear never commits.
    assign wr_en = LE && !busy && (RW != 5'd0);

    // Storage read muxes; GR0 falls through to the zero default.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int k = 1; k < 32; k++) begin
            if (RA == 5'(k)) rd_a = gr_q[k];
            if (RB == 5'(k)) rd_b = gr_q[k];
        end
    end

    // Read-port next values: GR0 zero first, then the write bypass (idle only), then storage.
    always_comb begin
        pa_d = rd_a;
        pb_d = rd_b;
        if (RA == 5'd0) begin
            pa_d = '0;
        end else if (LE && !busy && (RW == RA)) begin
            pa_d = PW;
        end
        if (RB == 5'd0) begin
            pb_d = '0;
        end else if (LE && !busy && (RW == RB)) begin
            pb_d = PW;
        end
    end

    // Clear engine next state: walk CNT from 1 to 31, returning to idle after the last register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (CLR) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd1;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // Register array update: the clear engine and writes are mutually exclusive since writes are blocked while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k < 32; k++) begin
                gr_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (busy && (cnt_q == 5'(k))) begin
                    gr_q[k] <= '0;
                end else if (wr_en && (RW == 5'(k))) begin
                    gr_q[k] <= PW;
                end
            end
        end
    end

    // Clear engine state, counter and read-port output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            pa_q    <= '0;
            pb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
        end
    end

    assign PA   = pa_q;
    assign PB   = pb_q;
    assign BUSY = busy;

endmodule

// File: tb/tb_register_bank_32x32.sv
// Directed testbench for register_bank_32x32 with hand-computed expected values.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Every comparison goes through check_val, which counts it and reports mismatches.
module tb_register_bank_32x32;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        LE;
    logic [4:0]  RW;
    logic [31:0] PW;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic [31:0] PA;
    logic [31:0] PB;
    logic        CLR;
    logic        BUSY;

    int checks   = 0;
    int failures = 0;
    int busy_cnt;

    register_bank_32x32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .LE      (LE),
        .RW      (RW),
        .PW      (PW),
        .RA      (RA),
        .RB      (RB),
        .PA      (PA),
        .PB      (PB),
        .CLR     (CLR),
        .BUSY    (BUSY)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rw, input logic [31:0] pw);
        LE = 1'b1;
        RW = rw;
        PW = pw;
        tick();
        LE = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base, input logic [31:0] step);
        for (int k = 1; k < 32; k++) begin
            wr(5'(k), base + step * k);
        end
    endtask

    task automatic rd(input logic [4:0] ra, input logic [4:0] rb);
        LE = 1'b0;
        RA = ra;
        RB = rb;
        tick();
    endtask

    task automatic read_all_zero(input string tag);
        for (int k = 0; k < 32; k++) begin
            rd(5'(k), 5'(31 - k));
            check_val($sformatf("%s_pa_%0d", tag, k), PA, 32'h0);
            check_val($sformatf("%s_pb_%0d", tag, 31 - k), PB, 32'h0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        LE = 1'b0; RW = 5'd0; PW = 32'h0; RA = 5'd0; RB = 5'd0; CLR = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pa", PA, 32'h0);
        check_val("rst_busy", {31'h0, BUSY}, 32'h0);
        reset_n = 1'b1;

        // 1. Reset values: make outputs nonzero, then reset mid-cycle with inputs still active.
        LE = 1'b1; RW = 5'd3; PW = 32'h0000_0055; RA = 5'd3; RB = 5'd3; CLR = 1'b1;
        tick();
        check_val("pre_rst_pa", PA, 32'h0000_0055);
        check_val("pre_rst_busy", {31'h0, BUSY}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst_pa", PA, 32'h0);
        check_val("async_rst_pb", PB, 32'h0);
        check_val("async_rst_busy", {31'h0, BUSY}, 32'h0);
        LE = 1'b0; CLR = 1'b0;
        tick();
        reset_n = 1'b1;
        read_all_zero("after_rst");

        // 2. Write/read all registers, GR0 write dropped.
        fill(32'h100, 32'h1);
        wr(5'd0, 32'hDEAD_BEEF);
        for (int k = 1; k < 32; k++) begin
            rd(5'(k), 5'd0);
            check_val($sformatf("wr_rd_gr%0d", k), PA, 32'h100 + k);
            check_val($sformatf("wr_rd_gr0_b%0d", k), PB, 32'h0);
        end
        rd(5'd0, 5'd0);
        check_val("gr0_pa", PA, 32'h0);

        // 3. Write-to-read bypass.
        wr(5'd5, 32'h1111_1111);
        LE = 1'b1; RW = 5'd5; PW = 32'h2222_2222; RA = 5'd5; RB = 5'd5;
        tick();
        check_val("byp_pa", PA, 32'h2222_2222);
        check_val("byp_pb", PB, 32'h2222_2222);
        rd(5'd5, 5'd5);
        check_val("byp_stored_pa", PA, 32'h2222_2222);
        LE = 1'b1; RW = 5'd0; PW = 32'h3333_3333; RA = 5'd0; RB = 5'd5;
        tick();
        LE = 1'b0;
        check_val("byp_gr0_pa", PA, 32'h0);
        check_val("byp_gr0_pb", PB, 32'h2222_2222);

        // 4. Clear sequence with mid-clear read, dropped write, ignored CLR and first accepted write at t+32.
        fill(32'hA5A5_A5A5, 32'h0);
        CLR = 1'b1;
        tick();                        // edge t
        CLR = 1'b0;
        busy_cnt = BUSY ? 1 : 0;
        for (int i = 1; i <= 32; i++) begin
            CLR = (i == 5);
            LE  = (i == 10) || (i == 32);
            RW  = (i == 10) ? 5'd7 : 5'd9;
            PW  = (i == 10) ? 32'h7 : 32'h99;
            RA  = 5'd20;
            RB  = 5'd7;
            tick();                    // edge t+i
            if (BUSY) busy_cnt++;
            if (i == 19) check_val("clr_gr20_t19", PA, 32'hA5A5_A5A5);
            if (i == 21) check_val("clr_gr20_t21", PA, 32'h0);
            if (i == 30) check_val("clr_busy_t30", {31'h0, BUSY}, 32'h1);
            if (i == 31) check_val("clr_busy_t31", {31'h0, BUSY}, 32'h0);
        end
        CLR = 1'b0; LE = 1'b0;
        check_val("clr_busy_cycles", busy_cnt, 32'd31);
        rd(5'd7, 5'd9);
        check_val("clr_dropped_wr_gr7", PA, 32'h0);
        check_val("clr_first_wr_gr9", PB, 32'h99);
        rd(5'd31, 5'd1);
        check_val("clr_gr31", PA, 32'h0);
        check_val("clr_gr1", PB, 32'h0);

        // 5. Simultaneous CLR and write in idle.
        CLR = 1'b1; LE = 1'b1; RW = 5'd31; PW = 32'hCAFE_F00D; RA = 5'd31; RB = 5'd0;
        tick();                        // edge t
        CLR = 1'b0; LE = 1'b0;
        check_val("sim_byp_t0", PA, 32'hCAFE_F00D);
        for (int i = 1; i <= 32; i++) begin
            tick();                    // edge t+i
            if (i == 1)  check_val("sim_gr31_t1", PA, 32'hCAFE_F00D);
            if (i == 31) check_val("sim_gr31_t31", PA, 32'hCAFE_F00D);
            if (i == 32) check_val("sim_gr31_t32", PA, 32'h0);
        end

        // 6. Reset in the middle of a clear.
        fill(32'h3C3C_0000, 32'h1);
        CLR = 1'b1;
        tick();                        // edge t
        CLR = 1'b0;
        repeat (12) tick();            // edge t+12
        check_val("midclr_busy_pre", {31'h0, BUSY}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_val("midclr_busy_rst", {31'h0, BUSY}, 32'h0);
        tick();
        reset_n = 1'b1;
        read_all_zero("midclr");
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        busy_cnt = BUSY ? 1 : 0;
        repeat (35) begin
            tick();
            if (BUSY) busy_cnt++;
        end
        check_val("reclr_busy_cycles", busy_cnt, 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
